disp_hex_pair: RTL and testbench

DISP_HEX_PAIR -- requirements
Module: disp_hex_pair

---
 rtl/disp_hex_pair_pkg.sv | 25 ++
 rtl/disp_hex_pair_sseg.sv | 13 +
 rtl/disp_hex_pair.sv | 65 ++++++
 tb/tb_disp_hex_pair.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/disp_hex_pair_pkg.sv
// Shared segment constants and the hex glyph table for the two-digit display.
// Segment bits are {g,f,e,d,c,b,a}, active-low, so a 0 lights the segment.
package disp_hex_pair_pkg;

    localparam int SEG_W = 7;
    localparam int NIBBLE_W = 4;
    localparam int BYTE_W = 8;

    typedef logic [SEG_W-1:0] seg_t;
    typedef logic [NIBBLE_W-1:0] nibble_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_MINUS = 7'h3F;

    // Packed so that index 0 is the rightmost entry: glyphs for F down to 0.
    localparam logic [15:0][SEG_W-1:0] HEX_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic seg_t blankOr(input logic forceBlank, input seg_t seg);
        return forceBlank ? SEG_BLANK : seg;
    endfunction

endpackage

// File: rtl/disp_hex_pair_sseg.sv
// Combinational nibble-to-seven-segment encoder for one hex digit.
module hex_to_sseg
    import disp_hex_pair_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    output logic [SEG_W-1:0]    seg_o
);

    always_comb begin
        seg_o = HEX_GLYPH[nibble_i];
    end

endmodule

// File: rtl/disp_hex_pair.sv
// Two-digit hex display driver: holds a byte and registers both digit patterns.
// Both outputs come straight from flops, so they change only on a clock edge.
module disp_hex_pair
    import disp_hex_pair_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              load,
    input  logic              blank,
    output logic [SEG_W-1:0]  disp0,
    output logic [SEG_W-1:0]  disp1
);

    logic [BYTE_W-1:0] data_q, data_d;
    logic [SEG_W-1:0]  disp0_q, disp0_d;
    logic [SEG_W-1:0]  disp1_q, disp1_d;
    logic [BYTE_W-1:0] shown;
    logic [SEG_W-1:0]  segLow, segHigh;
    logic              highIsZero;

    // A byte being loaded this edge is shown immediately, giving one cycle of latency.
    always_comb begin
        data_d = data_q;
        shown  = data_q;
        if (load) begin
            data_d = data_in;
            shown  = data_in;
        end
    end

    hex_to_sseg u_encLow (
        .nibble_i (shown[3:0]),
        .seg_o    (segLow)
    );

    hex_to_sseg u_encHigh (
        .nibble_i (shown[7:4]),
        .seg_o    (segHigh)
    );

    always_comb begin
        highIsZero = (shown[7:4] == 4'h0);
        disp0_d    = blankOr(blank, segLow);
        disp1_d    = blankOr(blank || (BLANK_LZ && highIsZero), segHigh);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            disp0_q <= SEG_BLANK;
            disp1_q <= SEG_BLANK;
        end else begin
            data_q  <= data_d;
            disp0_q <= disp0_d;
            disp1_q <= disp1_d;
        end
    end

    assign disp0 = disp0_q;
    assign disp1 = disp1_q;

endmodule

// File: tb/tb_disp_hex_pair.sv
// Self-checking bench for disp_hex_pair with and without leading-zero blanking.
module tb_disp_hex_pair;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       load = 1'b0;
    logic       blank = 1'b0;
    logic [6:0] disp0, disp1, lzDisp0, lzDisp1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    disp_hex_pair #(.BLANK_LZ(1'b0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .load    (load),
        .blank   (blank),
        .disp0   (disp0),
        .disp1   (disp1)
    );

    disp_hex_pair #(.BLANK_LZ(1'b1)) dutLz (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .load    (load),
        .blank   (blank),
        .disp0   (lzDisp0),
        .disp1   (lzDisp1)
    );

    typedef struct {
        logic       rstN;
        logic       ld;
        logic       blk;
        logic [7:0] din;
        logic [6:0] exp0;
        logic [6:0] exp1;
        logic [6:0] expLz0;
        logic [6:0] expLz1;
    } vec_t;

    typedef struct {
        bit         isSweep;
        logic [7:0] byteVal;
        logic [6:0] exp0;
        logic [6:0] exp1;
        logic [6:0] expLz0;
        logic [6:0] expLz1;
    } exp_t;

    exp_t scoreboard[$];

    // Reference decoder: returns {valid, nibble}; valid=0 for any non-glyph pattern.
    function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
        logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int n = 0; n < 16; n++) begin
            if (glyphs[n] == seg) return {1'b1, 4'(n)};
        end
        return 5'b0_0000;
    endfunction

    task automatic checkEq(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkDecode(input string name, input logic [6:0] seg, input logic [3:0] expNib);
        logic [4:0] dec;
        dec = decodeSeg(seg);
        checks++;
        if (dec !== {1'b1, expNib}) begin
            errors++;
            $display("[TB] FAIL %s: seg %h decodes to valid=%b nibble=%h, expected valid=1 nibble=%h",
                     name, seg, dec[4], dec[3:0], expNib);
        end
    endtask

    task automatic applyStimulus(input logic rstN, input logic ld, input logic blk,
                                 input logic [7:0] din, input exp_t e);
        rst_n   = rstN;
        load    = ld;
        blank   = blk;
        data_in = din;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
            return;
        end
        e = scoreboard.pop_front();
        if (e.isSweep) begin
            checkDecode({tag, " disp0"}, disp0, e.byteVal[3:0]);
            checkDecode({tag, " disp1"}, disp1, e.byteVal[7:4]);
            checkDecode({tag, " lz disp0"}, lzDisp0, e.byteVal[3:0]);
            if (e.byteVal[7:4] == 4'h0) checkEq({tag, " lz disp1"}, lzDisp1, 7'h7F);
            else checkDecode({tag, " lz disp1"}, lzDisp1, e.byteVal[7:4]);
        end else begin
            checkEq({tag, " disp0"}, disp0, e.exp0);
            checkEq({tag, " disp1"}, disp1, e.exp1);
            checkEq({tag, " lz disp0"}, lzDisp0, e.expLz0);
            checkEq({tag, " lz disp1"}, lzDisp1, e.expLz1);
        end
    endtask

    vec_t vecs[$];

    initial begin
        exp_t e;
        // rstN ld blk din   disp0  disp1  lz0    lz1
        vecs = '{
            '{1'b0, 1'b0, 1'b0, 8'h00, 7'h7F, 7'h7F, 7'h7F, 7'h7F},
            '{1'b0, 1'b0, 1'b0, 8'h00, 7'h7F, 7'h7F, 7'h7F, 7'h7F},
            '{1'b1, 1'b0, 1'b0, 8'h00, 7'h40, 7'h40, 7'h40, 7'h7F},
            '{1'b1, 1'b1, 1'b0, 8'hA5, 7'h12, 7'h08, 7'h12, 7'h08},
            '{1'b1, 1'b0, 1'b0, 8'hFF, 7'h12, 7'h08, 7'h12, 7'h08},
            '{1'b1, 1'b1, 1'b1, 8'h3C, 7'h7F, 7'h7F, 7'h7F, 7'h7F},
            '{1'b1, 1'b0, 1'b0, 8'h00, 7'h46, 7'h30, 7'h46, 7'h30},
            '{1'b1, 1'b1, 1'b0, 8'h07, 7'h78, 7'h40, 7'h78, 7'h7F},
            '{1'b1, 1'b1, 1'b0, 8'h10, 7'h40, 7'h79, 7'h40, 7'h79},
            '{1'b1, 1'b1, 1'b0, 8'h5A, 7'h08, 7'h12, 7'h08, 7'h12},
            '{1'b0, 1'b1, 1'b0, 8'h99, 7'h7F, 7'h7F, 7'h7F, 7'h7F},
            '{1'b1, 1'b0, 1'b0, 8'h99, 7'h40, 7'h40, 7'h40, 7'h7F},
            '{1'b1, 1'b1, 1'b1, 8'hE2, 7'h7F, 7'h7F, 7'h7F, 7'h7F},
            '{1'b1, 1'b0, 1'b1, 8'h00, 7'h7F, 7'h7F, 7'h7F, 7'h7F},
            '{1'b1, 1'b0, 1'b0, 8'h00, 7'h24, 7'h06, 7'h24, 7'h06},
            '{1'b1, 1'b0, 1'b0, 8'h77, 7'h24, 7'h06, 7'h24, 7'h06},
            '{1'b1, 1'b1, 1'b0, 8'h0F, 7'h0E, 7'h40, 7'h0E, 7'h7F}
        };

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            e = '{1'b0, 8'h00, vecs[i].exp0, vecs[i].exp1, vecs[i].expLz0, vecs[i].expLz1};
            applyStimulus(vecs[i].rstN, vecs[i].ld, vecs[i].blk, vecs[i].din, e);
            checkOutput($sformatf("vec%0d", i));
        end

        // Exhaustive load sweep, each byte shown one edge after it is driven.
        for (int b = 0; b < 256; b++) begin
            e = '{1'b1, 8'(b), 7'h00, 7'h00, 7'h00, 7'h00};
            applyStimulus(1'b1, 1'b1, 1'b0, 8'(b), e);
            checkOutput($sformatf("sweep%02h", b));
        end

        // Held value (FF) must survive several idle edges with changing data_in.
        for (int k = 0; k < 4; k++) begin
            e = '{1'b0, 8'h00, 7'h0E, 7'h0E, 7'h0E, 7'h0E};
            applyStimulus(1'b1, 1'b0, 1'b0, 8'(k * 8'h11), e);
            checkOutput($sformatf("hold%0d", k));
        end

        checks++;
        if (scoreboard.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d entries left, expected 0", scoreboard.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
